// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request stream into instruction memory,
// in-order response queue toward decode, and redirect flush with stale-response dropping.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [XLEN-1:0]            imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_inst,
  output logic [XLEN-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0] queue_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];

  logic            req_fire;
  logic            push;
  logic            pop;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] redirect_aligned;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   drop_flush;
  logic [CW-1:0]   count_next;

  // Queue slots plus in-flight requests never exceed DEPTH, so a response always has room.
  assign credit_used      = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid   = reset && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr    = fetch_pc;
  assign req_fire         = imem_req_valid && imem_req_ready;
  assign push             = imem_rsp_valid && (drop == '0) && !redirect_valid;
  assign pop              = out_valid && out_ready && !redirect_valid;
  assign redirect_aligned = redirect_pc & ~XLEN'(3);

  assign out_valid   = (count != '0);
  assign out_inst    = out_valid ? inst_mem[rd_ptr] : '0;
  assign out_pc      = out_valid ? pc_mem[rd_ptr] : '0;
  assign queue_count = count;

  always_comb begin
    outstanding_next = outstanding;
    if (req_fire && !imem_rsp_valid) outstanding_next = outstanding + CW'(1);
    else if (!req_fire && imem_rsp_valid) outstanding_next = outstanding - CW'(1);
  end

  // Outstanding already includes responses still pending a drop, so after a flush every
  // response still in flight is stale; the one arriving this cycle is discarded directly.
  always_comb begin
    drop_flush = outstanding;
    if (imem_rsp_valid) drop_flush = (outstanding == '0) ? '0 : outstanding - CW'(1);
  end

  always_comb begin
    count_next = count;
    if (push && !pop) count_next = count + CW'(1);
    else if (!push && pop) count_next = count - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
        rsp_pc   <= redirect_aligned;
        drop     <= drop_flush;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (imem_rsp_valid) begin
          if (drop != '0) drop <= drop - CW'(1);
          else rsp_pc <= rsp_pc + XLEN'(4);
        end
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count_next;
      end
    end
  end

  // Storage needs no reset: outputs are masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= rsp_pc;
      inst_mem[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule
